mmc1_serial_ctrl: RTL and testbench



---
 rtl/mmc1_serial_ctrl_pkg.sv | 22 ++
 rtl/mmc1_serial_ctrl_wr_filter.sv | 40 ++++
 rtl/mmc1_serial_ctrl.sv | 95 +++++++++
 tb/tb_mmc1_serial_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_serial_ctrl_pkg.sv
// Shared constants for the MMC1 serial-load sequencer.
// Save-state byte offsets, register selects and word length.
package mmc1_serial_ctrl_pkg;

  localparam logic [7:0] SS_OFS_STATE = 8'd0;
  localparam logic [7:0] SS_OFS_WORD  = 8'd1;

  typedef enum logic [1:0] {
    SEL_CTRL = 2'd0,
    SEL_CHR0 = 2'd1,
    SEL_CHR1 = 2'd2,
    SEL_PRG  = 2'd3
  } mmc1_sel_e;

  localparam int         COMMIT_LEN = 5;
  localparam logic [2:0] CNT_MAX    = 3'(COMMIT_LEN - 1);

  function automatic logic [2:0] clamp_cnt(input logic [2:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

endpackage

// File: rtl/mmc1_serial_ctrl_wr_filter.sv
// Write qualifier: tracks the previous write cycle and decides accept.
// MMC1_CONSEC_FILTER_EN drops writes that follow another write.
module mmc1_wr_filter
  import mmc1_serial_ctrl_pkg::*;
(
  input  logic m2,
  input  logic map_rst,
  input  logic cpu_ce,
  input  logic cpu_rw,
  input  logic ss_act,
  input  logic ld_en,
  input  logic ld_val,
  output logic we_prev,
  output logic accept
);

  logic wr_cyc;
  logic filter_ok;

  assign wr_cyc = !cpu_ce && !cpu_rw;

`ifdef MMC1_CONSEC_FILTER_EN
  assign filter_ok = !we_prev;
`else
  assign filter_ok = 1'b1;
`endif

  assign accept = wr_cyc && filter_ok && !ss_act;

  always_ff @(negedge m2) begin
    if (map_rst) begin
      we_prev <= 1'b0;
    end else if (ss_act) begin
      if (ld_en) we_prev <= ld_val;
    end else begin
      we_prev <= wr_cyc;
    end
  end

endmodule

// File: rtl/mmc1_serial_ctrl.sv
// MMC1 serial-load sequencer: 5-bit shift, commit strobe, save-state.
// Build with MMC1_CONSEC_FILTER_EN to drop RMW double writes.
module mmc1_serial_ctrl
  import mmc1_serial_ctrl_pkg::*;
#(
  parameter logic [7:0] SS_BASE = 8'd16
) (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       cpu_ce,
  input  logic       cpu_rw,
  input  logic [1:0] cpu_addr_sel,
  input  logic [7:0] cpu_dat,
  input  logic       ss_act,
  input  logic       ss_we,
  input  logic [7:0] ss_addr,
  output logic [7:0] ss_rdat,
  output logic       wr_stb,
  output logic [1:0] wr_sel,
  output logic [4:0] wr_dat,
  output logic       rst_stb,
  output logic [2:0] shift_cnt
);

  logic [3:0] buff;
  logic [2:0] cnt;
  logic       we_prev;
  logic       accept;
  logic       hit0;
  logic       hit1;

  assign hit0 = ss_addr == SS_BASE + SS_OFS_STATE;
  assign hit1 = ss_addr == SS_BASE + SS_OFS_WORD;

  mmc1_wr_filter u_filt (
    .m2      (m2),
    .map_rst (map_rst),
    .cpu_ce  (cpu_ce),
    .cpu_rw  (cpu_rw),
    .ss_act  (ss_act),
    .ld_en   (ss_we && hit0),
    .ld_val  (cpu_dat[7]),
    .we_prev (we_prev),
    .accept  (accept)
  );

  always_ff @(negedge m2) begin
    if (map_rst) begin
      buff    <= '0;
      cnt     <= '0;
      wr_stb  <= 1'b0;
      rst_stb <= 1'b0;
      wr_sel  <= '0;
      wr_dat  <= '0;
    end else begin
      wr_stb  <= 1'b0;
      rst_stb <= 1'b0;
      if (ss_act) begin
        if (ss_we && hit0) begin
          cnt  <= clamp_cnt(cpu_dat[6:4]);
          buff <= cpu_dat[3:0];
        end
        if (ss_we && hit1) begin
          wr_sel <= cpu_dat[6:5];
          wr_dat <= cpu_dat[4:0];
        end
      end else if (accept) begin
        // bit 7 wins over a pending fifth bit
        if (cpu_dat[7]) begin
          cnt     <= '0;
          buff    <= '0;
          rst_stb <= 1'b1;
        end else if (cnt == CNT_MAX) begin
          wr_dat <= {cpu_dat[0], buff};
          wr_sel <= cpu_addr_sel;
          wr_stb <= 1'b1;
          cnt    <= '0;
          buff   <= '0;
        end else begin
          buff <= {cpu_dat[0], buff[3:1]};
          cnt  <= cnt + 3'd1;
        end
      end
    end
  end

  assign shift_cnt = cnt;

  always_comb begin
    ss_rdat = 8'hFF;
    if (hit0) ss_rdat = {we_prev, cnt, buff};
    else if (hit1) ss_rdat = {1'b0, wr_sel, wr_dat};
  end

endmodule

// File: tb/tb_mmc1_serial_ctrl.sv
// Scoreboard bench for mmc1_serial_ctrl.
// Directed vectors; commits/resets checked by a separate monitor.
module tb_mmc1_serial_ctrl;

  localparam logic [7:0] SSB = 8'd16;

  logic       m2 = 1'b1;
  logic       map_rst = 1'b0;
  logic       cpu_ce = 1'b1;
  logic       cpu_rw = 1'b1;
  logic [1:0] cpu_addr_sel = '0;
  logic [7:0] cpu_dat = '0;
  logic       ss_act = 1'b0;
  logic       ss_we = 1'b0;
  logic [7:0] ss_addr = '0;
  logic [7:0] ss_rdat;
  logic       wr_stb;
  logic [1:0] wr_sel;
  logic [4:0] wr_dat;
  logic       rst_stb;
  logic [2:0] shift_cnt;

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] dat;
  } cmt_t;

  cmt_t exp_q[$];
  int   rst_pend = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  mmc1_serial_ctrl #(.SS_BASE(SSB)) dut (
    .m2           (m2),
    .map_rst      (map_rst),
    .cpu_ce       (cpu_ce),
    .cpu_rw       (cpu_rw),
    .cpu_addr_sel (cpu_addr_sel),
    .cpu_dat      (cpu_dat),
    .ss_act       (ss_act),
    .ss_we        (ss_we),
    .ss_addr      (ss_addr),
    .ss_rdat      (ss_rdat),
    .wr_stb       (wr_stb),
    .wr_sel       (wr_sel),
    .wr_dat       (wr_dat),
    .rst_stb      (rst_stb),
    .shift_cnt    (shift_cnt)
  );

  always #5 m2 = ~m2;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: state settles on the falling edge, sample on the rising one
  always @(posedge m2) begin
    if (!done) begin
      if (wr_stb) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wr_stb: sel %0d dat %b", wr_sel, wr_dat);
        end else begin
          cmt_t e;
          e = exp_q.pop_front();
          check("commit_sel", {6'd0, wr_sel}, {6'd0, e.sel});
          check("commit_dat", {3'd0, wr_dat}, {3'd0, e.dat});
        end
      end
      if (rst_stb) begin
        n_cmp++;
        if (rst_pend == 0) begin
          n_bad++;
          $display("FAIL unexpected_rst_stb: got 1 expected 0");
        end else begin
          rst_pend--;
        end
      end
    end
  end

  task automatic step(input logic ce, input logic rw, input logic [1:0] sel,
                      input logic [7:0] d, input logic rst, input logic sa,
                      input logic swe, input logic [7:0] sad);
    @(posedge m2);
    #1;
    cpu_ce = ce;
    cpu_rw = rw;
    cpu_addr_sel = sel;
    cpu_dat = d;
    map_rst = rst;
    ss_act = sa;
    ss_we = swe;
    ss_addr = sad;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic cpu_rd();
    step(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic cpu_wr(input logic [1:0] sel, input logic [7:0] d);
    step(1'b0, 1'b0, sel, d, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // write then read, so the write is settled on return
  task automatic wr_rd(input logic [1:0] sel, input logic [7:0] d);
    cpu_wr(sel, d);
    cpu_rd();
  endtask

  task automatic ss_rd(input logic [7:0] a, input logic [7:0] exp,
                       input string nm);
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, a);
    #1;
    check(nm, ss_rdat, exp);
  endtask

  task automatic ss_wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 2'd0, d, 1'b0, 1'b1, 1'b1, a);
  endtask

  task automatic pulse_rst();
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
  endtask

  initial begin
    logic [4:0] bits;
    logic [2:0] exp_cnt;

    pulse_rst();
    pulse_rst();
    check("rst_cnt", {5'd0, shift_cnt}, 8'd0);
    check("rst_sel", {6'd0, wr_sel}, 8'd0);
    check("rst_dat", {3'd0, wr_dat}, 8'd0);
    check("rst_stbs", {6'd0, wr_stb, rst_stb}, 8'd0);
    ss_rd(SSB, 8'h00, "rst_ss0");
    ss_rd(SSB + 8'd1, 8'h00, "rst_ss1");
    ss_rd(8'h03, 8'hFF, "ss_other");

    // bits 0,1,1,0,1 to $A000
    bits = 5'b10110;
    exp_q.push_back('{sel: 2'd1, dat: 5'b10110});
    for (int i = 0; i < 5; i++) begin
      wr_rd(2'd1, {7'd0, bits[i]});
      exp_cnt = (i == 4) ? 3'd0 : 3'(i + 1);
      check($sformatf("cnt_a%0d", i), {5'd0, shift_cnt}, {5'd0, exp_cnt});
    end
    idle();

    // 3 bits then bit-7 reset, then five ones to $E000
    wr_rd(2'd0, 8'h01);
    wr_rd(2'd0, 8'h00);
    wr_rd(2'd0, 8'h01);
    check("cnt_pre80", {5'd0, shift_cnt}, 8'd3);
    rst_pend++;
    wr_rd(2'd0, 8'h80);
    check("cnt_post80", {5'd0, shift_cnt}, 8'd0);
    exp_q.push_back('{sel: 2'd3, dat: 5'b11111});
    for (int i = 0; i < 5; i++) wr_rd(2'd3, 8'h01);
    check("cnt_e000", {5'd0, shift_cnt}, 8'd0);
    idle();

    // back-to-back write pair
    cpu_wr(2'd0, 8'h01);
    cpu_wr(2'd0, 8'h00);
    cpu_rd();
`ifdef MMC1_CONSEC_FILTER_EN
    check("cnt_b2b", {5'd0, shift_cnt}, 8'd1);
`else
    check("cnt_b2b", {5'd0, shift_cnt}, 8'd2);
`endif
    rst_pend++;
    wr_rd(2'd0, 8'h80);
    check("cnt_b2b_clr", {5'd0, shift_cnt}, 8'd0);

    // fifth bit carrying bit 7: reset only
    for (int i = 0; i < 4; i++) wr_rd(2'd2, 8'h00);
    check("cnt_at4", {5'd0, shift_cnt}, 8'd4);
    rst_pend++;
    wr_rd(2'd2, 8'h81);
    check("cnt_81", {5'd0, shift_cnt}, 8'd0);
    check("dat_keep", {3'd0, wr_dat}, 8'h1F);
    check("sel_keep", {6'd0, wr_sel}, 8'd3);

    // map_rst mid-word
    wr_rd(2'd0, 8'h01);
    wr_rd(2'd0, 8'h01);
    pulse_rst();
    check("cnt_maprst", {5'd0, shift_cnt}, 8'd0);
    ss_rd(SSB, 8'h00, "ss0_maprst");
    idle();
    bits = 5'b11001;
    exp_q.push_back('{sel: 2'd2, dat: 5'b11001});
    for (int i = 0; i < 5; i++) wr_rd(2'd2, {7'd0, bits[i]});
    idle();

    // save-state round trip
    wr_rd(2'd1, 8'h01);
    wr_rd(2'd1, 8'h01);
    wr_rd(2'd1, 8'h00);
    ss_rd(SSB, 8'h36, "ss0_save");
    ss_rd(SSB + 8'd1, 8'h59, "ss1_save");
    pulse_rst();
    ss_rd(SSB, 8'h00, "ss0_clob");
    ss_rd(SSB + 8'd1, 8'h00, "ss1_clob");
    ss_wr(SSB, 8'h70);
    ss_rd(SSB, 8'h40, "ss0_clamp");
    ss_wr(SSB, 8'h36);
    ss_wr(SSB + 8'd1, 8'h59);
    ss_rd(SSB, 8'h36, "ss0_rest");
    ss_rd(SSB + 8'd1, 8'h59, "ss1_rest");
    // CPU write during save-state is frozen out
    step(1'b0, 1'b0, 2'd1, 8'h01, 1'b0, 1'b1, 1'b0, SSB);
    ss_rd(SSB, 8'h36, "ss0_frozen");
    idle();
    wr_rd(2'd1, 8'h01);
    check("cnt_rest4", {5'd0, shift_cnt}, 8'd4);
    exp_q.push_back('{sel: 2'd1, dat: 5'b11011});
    wr_rd(2'd1, 8'h01);
    check("cnt_rest0", {5'd0, shift_cnt}, 8'd0);

    repeat (4) idle();
    done = 1'b1;
    check("commits_left", 8'(exp_q.size()), 8'd0);
    check("resets_left", 8'(rst_pend), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
